// File: rtl/stream_cypher_pkg.sv
// Shared definitions for the stream cypher transmit and receive sides.
// Holds the LFSR taps, the default seed and sync values, and the receive FSM states.
// lfsr_step8 is the single source of the keystream advance, so both ends stay bit-identical.
package stream_cypher_pkg;

  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
  localparam logic [7:0]  DEFAULT_SYNC = 8'hA5;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    LEN  = 2'd1,
    PAY  = 2'd2,
    CHK  = 2'd3
  } rx_state_t;

  // Eight Galois shifts, unrolled into one combinational step.
  function automatic logic [15:0] lfsr_step8(input logic [15:0] s_in);
    logic [15:0] s;
    s = s_in;
    for (int i = 0; i < 8; i++) begin
      if (s[0]) s = (s >> 1) ^ LFSR_TAPS;
      else      s = s >> 1;
    end
    return s;
  endfunction

endpackage

// File: rtl/stream_decypher_rx_if.sv
// Byte-stream bundle for the decypher receiver: ciphertext in, plaintext out, frame status.
// slave  = the receiver (drives in_ready and all output-side signals).
// master = the environment (drives in_data/in_valid and out_ready).
interface stream_decypher_rx_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       frame_ok;
  logic       frame_err;
  logic [7:0] drop_cnt;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last, frame_ok, frame_err, drop_cnt
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last, frame_ok, frame_err, drop_cnt
  );
endinterface

// File: rtl/stream_keystream.sv
// Keystream LFSR: reloads seed on load, advances 8 Galois steps per advance.
// Latency: new state visible the cycle after load/advance.
// Backpressure: none; the caller decides when to advance.
// Ports: clk, rst (sync, active-high), load, advance, state (16-bit LFSR value).
module stream_keystream
  import stream_cypher_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        advance,
  output logic [15:0] state
);

  always_ff @(posedge clk) begin
    if (rst || load) begin
      state <= SEED;
    end else if (advance) begin
      state <= lfsr_step8(state);
    end
  end

endmodule

// File: rtl/stream_decypher_rx.sv
// Frame receiver: hunts for SYNC, decrypts LEN/payload/CHK with the LFSR keystream, checks XOR sum.
// Latency: payload byte out 1 cycle after accept; frame_ok/frame_err pulse 1 cycle after CHK accept.
// Backpressure: in_ready follows the one-entry output register only during payload; else always 1.
// Ports: clk, rst (sync, active-high), bus (slave side of stream_decypher_rx_if).
module stream_decypher_rx
  import stream_cypher_pkg::*;
#(
  parameter logic [7:0]  SYNC = DEFAULT_SYNC,
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic                  clk,
  input  logic                  rst,
  stream_decypher_rx_if.slave   bus
);

  rx_state_t   state, state_nxt;
  logic [7:0]  cnt;
  logic [7:0]  chk;
  logic [7:0]  drop_cnt;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_last;
  logic        frame_ok;
  logic        frame_err;

  logic [15:0] ks_state;
  logic [7:0]  ks_byte;
  logic [7:0]  unused_ks_hi;
  logic [7:0]  plain;
  logic        in_ready;
  logic        xfer;
  logic        is_sync;
  logic        ks_load;
  logic        ks_adv;
  logic        out_load;

  assign {unused_ks_hi, ks_byte} = ks_state;

  // Output slot is free if empty or being drained this same cycle.
  assign in_ready = (state == PAY) ? (!out_valid || bus.out_ready) : 1'b1;
  assign xfer     = bus.in_valid && in_ready;
  assign plain    = bus.in_data ^ ks_byte;
  assign is_sync  = (bus.in_data == SYNC);
  assign ks_load  = xfer && (state == HUNT) && is_sync;
  assign ks_adv   = xfer && (state != HUNT);
  assign out_load = xfer && (state == PAY);

  stream_keystream #(.SEED(SEED)) u_keystream (
    .clk     (clk),
    .rst     (rst),
    .load    (ks_load),
    .advance (ks_adv),
    .state   (ks_state)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      HUNT: if (xfer && is_sync) state_nxt = LEN;
      LEN:  if (xfer) state_nxt = (plain != 8'd0) ? PAY : CHK;
      // cnt is never 0 here, so cnt==1 marks the final payload byte.
      PAY:  if (xfer && cnt == 8'd1) state_nxt = CHK;
      CHK:  if (xfer) state_nxt = HUNT;
      default: state_nxt = HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HUNT;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= 8'd0;
      chk       <= 8'd0;
      drop_cnt  <= 8'd0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      if (xfer) begin
        case (state)
          HUNT: if (!is_sync && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
          LEN: begin
            cnt <= plain;
            chk <= 8'd0;
          end
          PAY: begin
            cnt <= cnt - 8'd1;
            chk <= chk ^ plain;
          end
          CHK: begin
            frame_ok  <= (plain == chk);
            frame_err <= (plain != chk);
          end
          default: ;
        endcase
      end
    end
  end

  // One-entry output register; drains independently of the FSM state.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= 8'd0;
      out_last  <= 1'b0;
    end else if (out_load) begin
      out_valid <= 1'b1;
      out_data  <= plain;
      out_last  <= (cnt == 8'd1);
    end else if (bus.out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_data  = out_data;
  assign bus.out_valid = out_valid;
  assign bus.out_last  = out_last;
  assign bus.frame_ok  = frame_ok;
  assign bus.frame_err = frame_err;
  assign bus.drop_cnt  = drop_cnt;

endmodule

// File: tb/tb_stream_decypher_rx.sv
module tb_stream_decypher_rx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stream_decypher_rx_if bus();

  stream_decypher_rx #(.SYNC(8'hA5), .SEED(16'hACE1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [8:0] exp_q[$];   // {last, data}
  logic       stat_q[$];  // 1 = checksum good
  logic [7:0] pl_q[$];
  logic [7:0] ct_q[$];
  int         drop_model = 0;
  bit         rand_rdy   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Keystream rule written straight from the generator description.
  function automatic logic [15:0] ref_step8(input logic [15:0] s_in);
    logic [15:0] s;
    logic        lsb;
    s = s_in;
    for (int i = 0; i < 8; i++) begin
      lsb = s[0];
      s   = s >> 1;
      if (lsb) s = s ^ 16'hB400;
    end
    return s;
  endfunction

  // Encrypt pl_q into ct_q and record the expected responses.
  task automatic build_frame(input bit bad);
    logic [15:0] s;
    logic [7:0]  c;
    logic [7:0]  len8;
    logic [7:0]  r;
    int          len;
    s    = 16'hACE1;
    c    = 8'd0;
    len  = pl_q.size();
    len8 = len[7:0];
    ct_q.delete();
    ct_q.push_back(8'hA5);
    ct_q.push_back(len8 ^ s[7:0]);
    s = ref_step8(s);
    for (int i = 0; i < len; i++) begin
      exp_q.push_back({(i == len - 1), pl_q[i]});
      ct_q.push_back(pl_q[i] ^ s[7:0]);
      c = c ^ pl_q[i];
      s = ref_step8(s);
    end
    if (bad) begin
      r = 8'($urandom_range(1, 255));
      c = c ^ r;
    end
    stat_q.push_back(!bad);
    ct_q.push_back(c ^ s[7:0]);
  endtask

  // Present a byte and return just after the edge that accepted it.
  task automatic send(input logic [7:0] b);
    bit done;
    done = 0;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 500 && !done; k++) begin
      @(negedge clk);
      if (bus.in_ready) done = 1;
    end
    if (!done) fail_now("in_ready_timeout");
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_ct();
    for (int i = 0; i < ct_q.size(); i++) send(ct_q[i]);
  endtask

  task automatic send_junk();
    logic [7:0] b;
    b = 8'($urandom);
    if (b == 8'hA5) b = 8'h00;
    send(b);
    if (drop_model < 255) drop_model++;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_out_data"},  32'(bus.out_data),  32'd0);
    check({tag, "_out_last"},  32'(bus.out_last),  32'd0);
    check({tag, "_frame_ok"},  32'(bus.frame_ok),  32'd0);
    check({tag, "_frame_err"}, 32'(bus.frame_err), 32'd0);
    check({tag, "_drop_cnt"},  32'(bus.drop_cnt),  32'd0);
    check({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
  endtask

  // Random consumer backpressure.
  always @(posedge clk) begin
    #1;
    if (rand_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor / scoreboard.
  logic       prev_v, prev_r, prev_l;
  logic [7:0] prev_d;
  logic       e_stat;
  logic [8:0] e_byte;

  always @(negedge clk) begin
    if (rst) begin
      prev_v = 1'b0;
      prev_r = 1'b1;
    end else begin
      if (prev_v && !prev_r) begin
        check("hold_valid", 32'(bus.out_valid), 32'd1);
        check("hold_data",  32'({bus.out_last, bus.out_data}), 32'({prev_l, prev_d}));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_out_byte");
        end else begin
          e_byte = exp_q.pop_front();
          check("out_byte", 32'({bus.out_last, bus.out_data}), 32'(e_byte));
        end
      end
      if (bus.frame_ok || bus.frame_err) begin
        if (stat_q.size() == 0) begin
          fail_now("unexpected_frame_pulse");
        end else begin
          e_stat = stat_q.pop_front();
          check("frame_status", 32'({bus.frame_ok, bus.frame_err}), 32'({e_stat, !e_stat}));
        end
      end
      prev_v = bus.out_valid;
      prev_r = bus.out_ready;
      prev_d = bus.out_data;
      prev_l = bus.out_last;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_data   = 8'd0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // Single-byte frame from the reference vectors.
    exp_q.push_back({1'b1, 8'h3C});
    stat_q.push_back(1'b1);
    send(8'hA5); send(8'hE0); send(8'hF8);
    check("single_lat_valid", 32'(bus.out_valid), 32'd1);
    check("single_lat_data", 32'({bus.out_last, bus.out_data}), 32'h13C);
    send(8'h5E);
    check("single_ok_pulse", 32'(bus.frame_ok), 32'd1);
    @(posedge clk); #1;
    check("single_ok_width", 32'(bus.frame_ok), 32'd0);

    // Empty frame.
    stat_q.push_back(1'b1);
    send(8'hA5); send(8'hE1); send(8'hC4);
    check("empty_ok_pulse", 32'(bus.frame_ok), 32'd1);
    check("empty_no_valid", 32'(bus.out_valid), 32'd0);

    // Bad checksum.
    exp_q.push_back({1'b1, 8'h3C});
    stat_q.push_back(1'b0);
    send(8'hA5); send(8'hE0); send(8'hF8); send(8'h5F);
    check("bad_err_pulse", 32'({bus.frame_ok, bus.frame_err}), 32'b01);

    // Hunt: three junk bytes, then a good frame.
    send(8'h00); send(8'h11); send(8'h22);
    drop_model = 3;
    exp_q.push_back({1'b1, 8'h3C});
    stat_q.push_back(1'b1);
    send(8'hA5); send(8'hE0); send(8'hF8); send(8'h5E);
    check("hunt_drop_cnt", 32'(bus.drop_cnt), 32'd3);

    // Backpressure over a 2-byte payload.
    pl_q = '{8'($urandom), 8'($urandom)};
    build_frame(0);
    bus.out_ready = 1'b0;
    send(ct_q[0]); send(ct_q[1]); send(ct_q[2]);
    check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
    fork
      send(ct_q[3]);
      begin
        repeat (4) @(posedge clk);
        #1;
        check("bp_hold_data", 32'({bus.out_valid, bus.out_last, bus.out_data}), 32'({2'b10, pl_q[0]}));
        bus.out_ready = 1'b1;
      end
    join
    send(ct_q[4]);

    // Reset after LEN with an undrained payload byte pending.
    bus.out_ready = 1'b0;
    send(8'hA5); send(8'h02 ^ 8'hE1); send(8'h77 ^ 8'hC4);
    check("rst_pending_valid", 32'(bus.out_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("midrst");
    rst = 1'b0;
    bus.out_ready = 1'b1;
    drop_model = 0;
    exp_q.push_back({1'b1, 8'h3C});
    stat_q.push_back(1'b1);
    send(8'hA5); send(8'hE0); send(8'hF8); send(8'h5E);

    // Randomized frames with junk, corrupt checksums and random backpressure.
    rand_rdy = 1;
    for (int f = 0; f < 40; f++) begin
      int len;
      int nj;
      nj = $urandom_range(0, 2);
      for (int j = 0; j < nj; j++) send_junk();
      len = (f == 20) ? 255 : $urandom_range(0, 6);
      pl_q.delete();
      for (int i = 0; i < len; i++) pl_q.push_back(8'($urandom));
      build_frame($urandom_range(0, 3) == 0);
      send_ct();
    end
    rand_rdy = 0;
    bus.out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("rand_drop_cnt", 32'(bus.drop_cnt), 32'(drop_model));
    check("rand_bytes_drained", 32'(exp_q.size()), 32'd0);
    check("rand_status_drained", 32'(stat_q.size()), 32'd0);

    // drop_cnt saturation.
    for (int j = 0; j < 300; j++) send_junk();
    check("drop_saturate", 32'(bus.drop_cnt), 32'd255);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_decypher_rx.md
# stream_decypher_rx

Receive-side companion of the stream cypher. It accepts a byte stream of framed ciphertext and locks onto a plaintext sync byte. It regenerates the matching keystream from a shared seed, XOR-decrypts the length and payload bytes, checks a trailing checksum, and delivers plaintext through a one-entry valid/ready output register. It sits between the link byte source and the consuming logic.

## Interface
- `SYNC`, default 8'hA5: plaintext frame-start marker (never encrypted).
- `SEED`, default 16'hACE1: LFSR reload value. Must be nonzero.
- `clk` input 1: single clock; everything is on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `in_data` input 8: incoming byte (ciphertext except SYNC).
- `in_valid` input 1: in_data is valid.
- `in_ready` output 1: block accepts in_data this cycle. A transfer occurs when in_valid && in_ready.
- `out_data` output 8: decrypted payload byte.
- `out_valid` output 1: out_data is valid.
- `out_ready` input 1: consumer accepts out_data.
- `out_last` output 1: qualifies out_data as the final payload byte of the frame.
- `frame_ok` output 1: one-cycle pulse, checksum matched.
- `frame_err` output 1: one-cycle pulse, checksum mismatched.
- `drop_cnt` output 8: bytes discarded while hunting. Saturates at 255.

## Operation
- Keystream generator:
  - 16-bit Galois LFSR `s`. One step: lsb = s[0]; s = s >> 1; if lsb, s ^= 16'hB400.
  - Keystream byte for the current encrypted byte is s[7:0].
  - On each accepted encrypted byte (LEN, payload, CHK), s advances exactly 8 steps in one cycle.
  - s reloads SEED when SYNC is accepted in HUNT.
- Decryption: plain = in_data ^ s[7:0].
- FSM states:
  - HUNT:
    - Accepted byte == SYNC → reload LFSR, go to LEN.
    - Any other accepted byte → increment drop_cnt, stay in HUNT.
    - The LFSR does not advance in HUNT.
  - LEN:
    - Accepted byte → cnt = plain, clear chk, advance LFSR.
    - Go to PAY if cnt != 0, else go to CHK.
  - PAY:
    - Accepted byte → load the output register with plain.
    - out_last = (cnt == 1).
    - chk ^= plain; cnt -= 1; advance LFSR.
    - Go to CHK when cnt reaches 0.
  - CHK:
    - Accepted byte → compare plain with chk.
    - Pulse frame_ok or frame_err on the next cycle.
    - Advance LFSR, go to HUNT.
- Checksum: 8-bit XOR of plaintext payload bytes only. LEN is excluded. Empty payload gives chk = 0.
- in_ready:
  - Constant 1 in HUNT, LEN and CHK.
  - In PAY: in_ready = !out_valid || out_ready. A full register drained the same cycle may be refilled.
- Output register:
  - out_valid sets on a PAY transfer.
  - out_valid clears on out_ready when no new load happens in that cycle.
  - out_data and out_last are held stable while out_valid && !out_ready.
- A SYNC value seen inside a frame is treated as ciphertext. There is no mid-frame resync.
- Output drain is independent of FSM state. A last byte still pending while CHK is processed remains valid until taken.

## Timing
- Reset values:
  - Outputs: out_valid=0, out_data=0, out_last=0, frame_ok=0, frame_err=0, drop_cnt=0, in_ready=1.
  - Internal: state=HUNT, s=SEED, cnt=0, chk=0.
- Latency:
  - A payload byte accepted in cycle N appears on out_data with out_valid in cycle N+1.
  - A CHK byte accepted in cycle N pulses frame_ok/frame_err in cycle N+1, for exactly 1 cycle.
- Throughput: 1 byte/cycle with out_ready held high.
- Reset asserted mid-frame:
  - On the next edge: discard the frame and any pending output byte.
  - No frame_ok/frame_err pulse.
  - drop_cnt is cleared.
- LEN = 255 is legal.
- cnt is 8-bit. It never wraps, because decrement happens only while cnt != 0.

## Structure
- Package `stream_cypher_pkg` holds:
  - `LFSR_TAPS` = 16'hB400.
  - Default `SEED` and `SYNC`.
  - State enum `rx_state_t` {HUNT, LEN, PAY, CHK}.
  - Function `lfsr_step8(logic [15:0]) → logic [15:0]`, shared with the transmit side.
- One sub-module, `stream_keystream`:
  - Inputs: clk, rst, load, advance.
  - Output: 16-bit state.
  - Also instantiated by the transmitter, so both ends stay bit-identical.

## Test plan
- Single-byte frame. Stimulus: A5, E0, F8, 5E with out_ready=1. Response:
  - out_data = 3C with out_last = 1.
  - frame_ok pulses one cycle after 5E.
  - Keystream bytes are E1, C4, 62.
- Empty frame. Stimulus: A5, E1, C4. Response: no out_valid; frame_ok pulses.
- Bad checksum. Stimulus: A5, E0, F8, 5F. Response: out_data = 3C is delivered; frame_err pulses; frame_ok stays 0.
- Hunt. Stimulus: 00, 11, 22, then a valid frame. Response: drop_cnt = 3, and the frame decodes as in the single-byte frame test.
- Backpressure. Stimulus: out_ready=0 during the payload of a 2-byte frame. Response:
  - in_ready drops after the first payload byte.
  - out_data holds until out_ready returns.
  - No byte is lost or duplicated.
- Reset mid-frame. Stimulus: rst pulsed after LEN. Response:
  - All outputs return to their reset values.
  - A following frame decodes correctly from SEED.
